// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath word type and MEM-stage state encoding
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} memstate_t;
endpackage

// File: rtl/mem_access_unit_link_reg.sv
// link_reg: LL/SC reservation register with set, clear and word-address match
module link_reg #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ll_done_i,
  input  logic              sc_done_i,
  input  logic              sw_done_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic              snoop_inv_i,
  input  logic [WORD_W-1:0] snoop_addr_i,
  output logic              link_valid_o,
  output logic [WORD_W-1:0] link_addr_o
);
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              snoop_old, snoop_new, sw_hit;
  // A completing LL survives a same-cycle snoop unless that snoop hits the newly linked word
  always_comb begin
    snoop_old = snoop_inv_i & (snoop_addr_i[WORD_W-1:2] == addr_q[WORD_W-1:2]);
    snoop_new = snoop_inv_i & (snoop_addr_i[WORD_W-1:2] == addr_i[WORD_W-1:2]);
    sw_hit    = sw_done_i & (addr_i[WORD_W-1:2] == addr_q[WORD_W-1:2]);
    addr_d    = ll_done_i ? addr_i : addr_q;
    valid_d   = ll_done_i ? ~snoop_new : valid_q & ~(sc_done_i | sw_hit | snoop_old);
  end
  // Reservation state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end
  assign link_valid_o = valid_q;
  assign link_addr_o  = addr_q;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage dcache request controller feeding the MEM/WB latch
module mem_access_unit #(
  parameter int WORD_W  = 32,
  parameter bit LINK_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              ll_in,
  input  logic              sc_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] store_in,
  input  logic              pipe_en,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] wdat_out,
  output logic              mem_stall,
  output logic              mem_done
);
  import cpu_types_pkg::*;
  memstate_t         state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d, result, link_addr;
  logic              link_valid, op, sc_fail, req, fail_done, complete, done_now;
  // Requests are combinational for zero-latency hits; gating with nRST drops them the instant reset asserts
  always_comb begin
    op        = valid_in & (MemRead_in | MemWrite_in);
    sc_fail   = LINK_EN & sc_in & ~(link_valid & (link_addr[WORD_W-1:2] == addr_in[WORD_W-1:2]));
    req       = nRST & (state_q != DONE) & op & ~sc_fail;
    fail_done = nRST & (state_q != DONE) & op & sc_fail;
    complete  = req & dhit;
    done_now  = complete | fail_done;
    result    = complete ? (MemRead_in ? dmemload : WORD_W'(LINK_EN & sc_in)) : '0;
    dmemREN   = req & MemRead_in;
    dmemWEN   = req & MemWrite_in;
    dmemaddr  = req ? addr_in : '0;
    dmemstore = req ? store_in : '0;
    wdat_out  = (state_q == DONE) ? hold_q : result;
    mem_stall = req & ~dhit;
    mem_done  = (state_q == DONE) | done_now;
    hold_d    = done_now ? result : hold_q;
    state_d   = ((state_q == DONE) | done_now) ? (pipe_en ? IDLE : DONE) : (req ? ACCESS : IDLE);
  end
  // Access state and captured write-back value
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
  link_reg #(.WORD_W(WORD_W)) u_link (
    .CLK         (CLK),
    .nRST        (nRST),
    .ll_done_i   (LINK_EN & complete & ll_in),
    .sc_done_i   (LINK_EN & done_now & sc_in),
    .sw_done_i   (LINK_EN & complete & MemWrite_in),
    .addr_i      (addr_in),
    .snoop_inv_i (snoop_inv),
    .snoop_addr_i(snoop_addr),
    .link_valid_o(link_valid),
    .link_addr_o (link_addr)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, reset corner case and randomized model check
module tb_mem_access_unit;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        valid_in, MemRead_in, MemWrite_in, ll_in, sc_in, pipe_en, dhit, snoop_inv;
  logic [31:0] addr_in, store_in, dmemload, snoop_addr;
  logic        dmemREN, dmemWEN, mem_stall, mem_done;
  logic [31:0] dmemaddr, dmemstore, wdat_out;
  int          passed = 0, total = 0;

  typedef struct {
    logic v, rd, wr, ll, sc;
    logic [31:0] a, s;
    logic pe, dh;
    logic [31:0] ld;
    logic si;
    logic [31:0] sa;
    logic [99:0] x;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] pool [3] = '{32'h300, 32'h304, 32'h100};
  wire  [99:0] outs = {dmemREN, dmemWEN, dmemaddr, dmemstore, wdat_out, mem_stall, mem_done};

  mem_access_unit #(.WORD_W(32), .LINK_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .valid_in(valid_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ll_in(ll_in), .sc_in(sc_in), .addr_in(addr_in), .store_in(store_in), .pipe_en(pipe_en), .dhit(dhit),
    .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .wdat_out(wdat_out), .mem_stall(mem_stall), .mem_done(mem_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [99:0] ex(int ren, int wen, logic [31:0] ma, logic [31:0] ms, logic [31:0] wd, int st, int dn);
    return {1'(ren), 1'(wen), ma, ms, wd, 1'(st), 1'(dn)};
  endfunction

  function automatic vec_t mk(int v, int rd, int wr, int ll, int sc, logic [31:0] a, logic [31:0] s, int pe, int dh,
                              logic [31:0] ld, int si, logic [31:0] sa, logic [99:0] x);
    return '{1'(v), 1'(rd), 1'(wr), 1'(ll), 1'(sc), a, s, 1'(pe), 1'(dh), ld, 1'(si), sa, x};
  endfunction

  task automatic check(input string name, input logic [99:0] got, input logic [99:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic drive(input vec_t t);
    valid_in = t.v; MemRead_in = t.rd; MemWrite_in = t.wr; ll_in = t.ll; sc_in = t.sc;
    addr_in = t.a; store_in = t.s; pipe_en = t.pe; dhit = t.dh; dmemload = t.ld;
    snoop_inv = t.si; snoop_addr = t.sa;
  endtask

  task automatic step(input string name, input vec_t t);
    drive(t);
    @(negedge CLK);
    check(name, outs, t.x);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit          m_parked, m_lv, op, fail, stalled;
    logic [31:0] m_held;
    logic [29:0] m_lw;
    logic [99:0] xp;
    logic        xr, xw, xs, xd;
    logic [31:0] xa, xst, xwd;
    int          k;
    // Outputs must stay quiet under reset even with a live, hitting load presented
    drive(mk(1,1,0,0,0,'h100,0,1,1,'hDEADBEEF,0,0, 0));
    @(negedge CLK);
    check("reset_quiet", outs, ex(0,0,0,0,0,0,0));
    @(posedge CLK);
    #1;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0));
    nRST = 1'b1;
    tbl.push_back(mk(1,1,0,0,0,'h100,0,1,1,'hDEADBEEF,0,0,   ex(1,0,'h100,0,'hDEADBEEF,0,1)));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0,                ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1,0,1,0,0,'h200,'h1234,0,0,0,0,0,       ex(0,1,'h200,'h1234,0,1,0)));
    tbl.push_back(mk(1,0,1,0,0,'h200,'h1234,0,0,0,0,0,       ex(0,1,'h200,'h1234,0,1,0)));
    tbl.push_back(mk(1,0,1,0,0,'h200,'h1234,0,0,0,0,0,       ex(0,1,'h200,'h1234,0,1,0)));
    tbl.push_back(mk(1,0,1,0,0,'h200,'h1234,1,1,0,0,0,       ex(0,1,'h200,'h1234,0,0,1)));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0,                ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1,1,0,0,0,'h104,0,0,1,'hCAFEF00D,0,0,   ex(1,0,'h104,0,'hCAFEF00D,0,1)));
    tbl.push_back(mk(1,1,0,0,0,'h104,0,0,1,'h11111111,0,0,   ex(0,0,0,0,'hCAFEF00D,0,1)));
    tbl.push_back(mk(1,1,0,0,0,'h104,0,1,1,'h22222222,0,0,   ex(0,0,0,0,'hCAFEF00D,0,1)));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0,                ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1,1,0,1,0,'h300,0,1,1,'h77,0,0,         ex(1,0,'h300,0,'h77,0,1)));
    tbl.push_back(mk(1,0,1,0,1,'h300,5,1,1,0,0,0,            ex(0,1,'h300,5,1,0,1)));
    tbl.push_back(mk(1,0,1,0,1,'h300,5,1,1,0,0,0,            ex(0,0,0,0,0,0,1)));
    tbl.push_back(mk(1,1,0,1,0,'h300,0,1,1,'h9,0,0,          ex(1,0,'h300,0,'h9,0,1)));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,1,'h300,            ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1,0,1,0,1,'h300,5,1,1,0,0,0,            ex(0,0,0,0,0,0,1)));
    tbl.push_back(mk(1,1,0,1,0,'h300,0,1,1,'h9,0,0,          ex(1,0,'h300,0,'h9,0,1)));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,1,'h304,            ex(0,0,0,0,0,0,0)));
    tbl.push_back(mk(1,0,1,0,1,'h302,6,1,1,0,0,0,            ex(0,1,'h302,6,1,0,1)));
    tbl.push_back(mk(1,1,0,1,0,'h300,0,1,1,'h9,1,'h300,      ex(1,0,'h300,0,'h9,0,1)));
    tbl.push_back(mk(1,0,1,0,1,'h300,5,1,1,0,0,0,            ex(0,0,0,0,0,0,1)));
    tbl.push_back(mk(1,1,0,1,0,'h400,0,1,1,'hAB,1,'h500,     ex(1,0,'h400,0,'hAB,0,1)));
    tbl.push_back(mk(1,0,1,0,1,'h400,7,1,1,0,0,0,            ex(0,1,'h400,7,1,0,1)));
    tbl.push_back(mk(1,0,1,0,1,'h400,7,0,1,0,0,0,            ex(0,0,0,0,0,0,1)));
    tbl.push_back(mk(1,0,1,0,1,'h400,7,1,1,0,0,0,            ex(0,0,0,0,0,0,1)));
    tbl.push_back(mk(1,1,0,1,0,'h500,0,1,1,'h1,0,0,          ex(1,0,'h500,0,'h1,0,1)));
    tbl.push_back(mk(1,0,1,0,0,'h500,2,1,1,0,0,0,            ex(0,1,'h500,2,0,0,1)));
    tbl.push_back(mk(1,0,1,0,1,'h500,3,1,1,0,0,0,            ex(0,0,0,0,0,0,1)));
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);
    // Reset in the middle of a stalled access
    step("rst_ll", mk(1,1,0,1,0,'h600,0,1,1,'h5,0,0,          ex(1,0,'h600,0,'h5,0,1)));
    step("rst_lw", mk(1,1,0,0,0,'h700,0,0,0,0,0,0,            ex(1,0,'h700,0,0,1,0)));
    @(negedge CLK);
    check("rst_access", outs, ex(1,0,'h700,0,0,1,0));
    #2 nRST = 1'b0;
    #1 check("rst_async_drop", outs, ex(0,0,0,0,0,0,0));
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step("rst_idle", mk(0,0,0,0,0,0,0,1,0,0,0,0,               ex(0,0,0,0,0,0,0)));
    step("rst_link", mk(1,0,1,0,1,'h600,9,1,1,0,0,0,          ex(0,0,0,0,0,0,1)));
    // Randomized run against a transaction-level reference
    nRST = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0));
    @(posedge CLK);
    #1 nRST = 1'b1;
    m_parked = 0; m_lv = 0; m_held = 0; m_lw = 0; stalled = 0;
    for (int c = 0; c < 400; c++) begin
      if (!stalled) begin
        k = int'($urandom_range(0, 5));
        valid_in = (k != 5); MemRead_in = (k == 1 || k == 3 || k == 5); MemWrite_in = (k == 2 || k == 4);
        ll_in = (k == 3); sc_in = (k == 4);
        addr_in = pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
        store_in = $urandom;
      end
      dhit = ($urandom_range(0, 2) != 0);
      dmemload = $urandom;
      snoop_inv = ($urandom_range(0, 3) == 0);
      snoop_addr = pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
      op = valid_in && (MemRead_in || MemWrite_in);
      fail = sc_in && !(m_lv && addr_in[31:2] == m_lw);
      xr = 0; xw = 0; xa = 0; xst = 0; xwd = 0; xs = 0; xd = 0;
      if (m_parked) begin
        xwd = m_held; xd = 1;
      end else if (op && !fail) begin
        xr = MemRead_in; xw = MemWrite_in; xa = addr_in; xst = store_in;
        if (dhit) begin
          xwd = MemRead_in ? dmemload : {31'b0, sc_in};
          xd = 1;
        end else xs = 1;
      end else if (op) xd = 1;
      pipe_en = xs ? 1'b0 : 1'($urandom_range(0, 1));
      xp = {xr, xw, xa, xst, xwd, xs, xd};
      @(negedge CLK);
      check($sformatf("rand%0d", c), outs, xp);
      @(posedge CLK);
      if (!m_parked && xd && ll_in) begin
        m_lw = addr_in[31:2];
        m_lv = !(snoop_inv && snoop_addr[31:2] == addr_in[31:2]);
      end else if ((!m_parked && xd && (sc_in || (MemWrite_in && addr_in[31:2] == m_lw))) ||
                   (snoop_inv && snoop_addr[31:2] == m_lw)) m_lv = 0;
      if (m_parked) m_parked = !pipe_en;
      else if (xd) begin
        m_held = xwd;
        m_parked = !pipe_en;
      end
      stalled = xs;
      #1;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
